// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the IF/ID/EX/WB hazard and forwarding controller:
// operand-forward select encodings, register-address width, controller state
// type and the forward-priority helper.
package pipeline_defs;

    localparam int unsigned REG_W = 3;

    // EX-stage operand mux select encodings
    localparam logic [1:0] FWD_REGFILE = 2'b00;  // value read from register file
    localparam logic [1:0] FWD_EXWB    = 2'b01;  // ALU result of the instruction one ahead
    localparam logic [1:0] FWD_RETIRE  = 2'b10;  // final write data in the WB retire latch

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } ctrl_state_t;

    // Younger producer (EX) wins over older (WB); a load in EX is never a
    // forward source because its data is not ready yet.
    function automatic logic [1:0] fwd_select(input logic match_ex,
                                              input logic ex_load,
                                              input logic match_wb);
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (match_ex && !ex_load) begin
            sel = FWD_EXWB;
        end else if (match_wb) begin
            sel = FWD_RETIRE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_cmp.sv
// hazard_cmp: per-source dependency comparator.
// Compares one ID source address against the EX and WB destination shadows.
// Ports:
//   src, src_used             source address and "instruction really reads it"
//   ex_rd/ex_we/ex_v/ex_load  EX shadow
//   wb_rd/wb_we/wb_v          WB shadow
//   match_ex, match_wb        write-enabled destination match in EX / WB
//   load_use                  source depends on a load still in EX
module hazard_cmp #(
    parameter int unsigned REG_W   = 3,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic [REG_W-1:0] src,
    input  logic             src_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_we,
    input  logic             ex_v,
    input  logic             ex_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    input  logic             wb_v,
    output logic             match_ex,
    output logic             match_wb,
    output logic             load_use
);

    logic src_live;

    // A hardwired-zero r0 never depends on anything
    assign src_live = src_used && !(R0_ZERO && (src == '0));

    assign match_ex = src_live && ex_v && ex_we && (ex_rd == src);
    assign match_wb = src_live && wb_v && wb_we && (wb_rd == src);
    assign load_use = match_ex && ex_load;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: hazard / forwarding controller for the 8-bit,
// 8-register IF/ID/EX/WB core.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_valid, id_rs1(_used), id_rs2(_used), id_rd, id_we, id_is_load
//                                      instruction currently in ID
//   flush                              taken branch in EX kills the ID instruction
//   stall_id                           hold PC and IF/ID latch
//   bubble_ex                          insert a NOP into ID/EX
//   freeze                             hold every pipeline latch (multi-cycle load)
//   fwd_sel_a, fwd_sel_b               registered EX operand source selects
module hazard_forward_ctrl #(
    parameter int unsigned REG_W    = pipeline_defs::REG_W,
    parameter int unsigned LOAD_LAT = 2,
    parameter bit          R0_ZERO  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
);

    import pipeline_defs::ctrl_state_t;
    import pipeline_defs::RUN;
    import pipeline_defs::LOAD_WAIT;
    import pipeline_defs::FWD_REGFILE;
    import pipeline_defs::fwd_select;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_we_q, ex_we_d;
    logic             ex_load_q, ex_load_d;
    logic             ex_v_q, ex_v_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic             wb_v_q, wb_v_d;

    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;

    logic a_match_ex, a_match_wb, a_load_use;
    logic b_match_ex, b_match_wb, b_load_use;
    logic freeze_c, flush_eff_c, load_use_c, bubble_c, stall_c, load_enter_c;

    hazard_cmp #(.REG_W(REG_W), .R0_ZERO(R0_ZERO)) u_cmp_a (
        .src      (id_rs1),
        .src_used (id_valid && id_rs1_used),
        .ex_rd    (ex_rd_q),
        .ex_we    (ex_we_q),
        .ex_v     (ex_v_q),
        .ex_load  (ex_load_q),
        .wb_rd    (wb_rd_q),
        .wb_we    (wb_we_q),
        .wb_v     (wb_v_q),
        .match_ex (a_match_ex),
        .match_wb (a_match_wb),
        .load_use (a_load_use)
    );

    hazard_cmp #(.REG_W(REG_W), .R0_ZERO(R0_ZERO)) u_cmp_b (
        .src      (id_rs2),
        .src_used (id_valid && id_rs2_used),
        .ex_rd    (ex_rd_q),
        .ex_we    (ex_we_q),
        .ex_v     (ex_v_q),
        .ex_load  (ex_load_q),
        .wb_rd    (wb_rd_q),
        .wb_we    (wb_we_q),
        .wb_v     (wb_v_q),
        .match_ex (b_match_ex),
        .match_wb (b_match_wb),
        .load_use (b_load_use)
    );

    // Stall/bubble decode: freeze dominates, then flush beats load-use
    always_comb begin
        freeze_c     = (state_q == LOAD_WAIT);
        flush_eff_c  = !freeze_c && (flush || pend_q);
        load_use_c   = a_load_use || b_load_use;
        bubble_c     = !freeze_c && (flush_eff_c || load_use_c);
        stall_c      = freeze_c || (!flush_eff_c && load_use_c);
        load_enter_c = !freeze_c && id_valid && !bubble_c && id_is_load;
    end

    assign freeze    = freeze_c;
    assign stall_id  = stall_c;
    assign bubble_ex = bubble_c;
    assign fwd_sel_a = fwd_a_q;
    assign fwd_sel_b = fwd_b_q;

    // Next state for shadows, forward selects, pending flush and load FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        ex_rd_d   = ex_rd_q;
        ex_we_d   = ex_we_q;
        ex_load_d = ex_load_q;
        ex_v_d    = ex_v_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = wb_we_q;
        wb_v_d    = wb_v_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;

        if (!freeze_c) begin
            wb_rd_d   = ex_rd_q;
            wb_we_d   = ex_we_q;
            wb_v_d    = ex_v_q;
            ex_rd_d   = id_rd;
            ex_we_d   = id_we;
            ex_load_d = id_is_load;
            ex_v_d    = id_valid && !bubble_c;
            pend_d    = 1'b0;
            if (bubble_c) begin
                fwd_a_d = FWD_REGFILE;
                fwd_b_d = FWD_REGFILE;
            end else begin
                fwd_a_d = fwd_select(a_match_ex, ex_load_q, a_match_wb);
                fwd_b_d = fwd_select(b_match_ex, ex_load_q, b_match_wb);
            end
        end else if (flush) begin
            // Branch resolved while frozen: remember it for the first free cycle
            pend_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if ((LOAD_LAT > 1) && load_enter_c) begin
                    state_d = LOAD_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            LOAD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            ex_rd_q   <= '0;
            ex_we_q   <= 1'b0;
            ex_load_q <= 1'b0;
            ex_v_q    <= 1'b0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_v_q    <= 1'b0;
            fwd_a_q   <= FWD_REGFILE;
            fwd_b_q   <= FWD_REGFILE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ex_rd_q   <= ex_rd_d;
            ex_we_q   <= ex_we_d;
            ex_load_q <= ex_load_d;
            ex_v_q    <= ex_v_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            wb_v_q    <= wb_v_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
        end
    end

endmodule
